div_seq: RTL and testbench
==========================

# div_seq

Iterative 32-bit divider sequencer for the MIPS execute stage. It accepts a DIV/DIVU operation from E, runs one radix-2 restoring step per cycle, and returns the quotient and remainder for HI/LO. Its `ready` output is the `div_ready` input of the hazard unit. The hazard unit holds E, and stalls D/F, while a divide is in E and `ready` is low.

## Interface

Parameters:
- `WIDTH`, default 32: operand width. The iteration count equals `WIDTH`.

Ports:
- `clk`: input, 1 bit. Single clock; rising edge.
- `resetn`: input, 1 bit. Asynchronous, active-low reset.
- `start`: input, 1 bit. A divide is in E. Driven as (alucontrolE == DIV (6'b011100) or DIVU (6'b001100)).
- `signed_div`: input, 1 bit. 1 selects DIV; 0 selects DIVU. Sampled with `start`.
- `annul`: input, 1 bit. Cancels the operation in flight (E flush or exception).
- `dividend`: input, WIDTH bits. The rs operand, sampled on start acceptance.
- `divisor`: input, WIDTH bits. The rt operand, sampled on start acceptance.
- `result`: output, 2*WIDTH bits. {remainder (HI), quotient (LO)}.
- `ready`: output, 1 bit. One-cycle pulse; `result` is valid in this cycle.
- `busy`: output, 1 bit. High in the BUSY and DONE states.

## Operation

States:
- IDLE: waits for `start`.
- BUSY: one iteration per cycle; `count` runs 0..WIDTH-1.
- DONE: asserts `ready` for one cycle.

Transitions:
- IDLE → BUSY when `start` & ~`annul` & `divisor` != 0.
- IDLE → DONE when `start` & ~`annul` & `divisor` == 0 (divide by zero).
- BUSY → DONE when `count` == WIDTH-1.
- DONE → IDLE unconditionally.
- Any state → IDLE on `annul` (takes priority over everything else). `ready` is not asserted; `result` keeps its previous value.

Operation rules:
- `start` is ignored in BUSY and DONE. The pipeline advances on the `ready` edge, so `start` in the cycle after DONE belongs to a new instruction.
- Acceptance, signed: latch |dividend| and |divisor|. Record `q_neg` = sign(dividend) XOR sign(divisor) and `r_neg` = sign(dividend). Unsigned: latch operands as-is, with `q_neg` = `r_neg` = 0.
- Iteration: the partial remainder is WIDTH+1 bits. Shift in the dividend MSB, trial-subtract the divisor (WIDTH+1 bits), and keep the result if it is non-negative. The quotient bit is the inverted borrow.
- Final step: negate the quotient if `q_neg` and the remainder if `r_neg`. Register the result on the BUSY→DONE edge.
- Width rule: magnitudes are computed in WIDTH+1 bits, so |0x80000000| = 0x80000000 is representable. For 0x80000000 / -1 signed: quotient 0x80000000, remainder 0.
- Divide by zero: `result` = {dividend, {WIDTH{1'b1}}}, with no sign correction.
- `result` holds its value from DONE until the next DONE.

## Timing

- Reset values: state IDLE; `ready` 0; `busy` 0; `result` 0; `count` 0.
- Normal latency: `start` sampled at edge T; BUSY for cycles T+1..T+WIDTH; `ready` = 1 in cycle T+WIDTH+1 (T+33 for WIDTH=32).
- Divide-by-zero latency: `ready` = 1 in cycle T+1.
- Outputs: `ready`, `busy`, and `result` are registered, with no combinational path from the inputs. The hazard unit's `stall_divE` is therefore low exactly in the DONE cycle.
- Back-to-back: a new `start` is accepted in the cycle after DONE, giving a minimum spacing of WIDTH+2 cycles.
- Reset mid-operation: an asynchronous return to the reset values, with no `ready` pulse.

## Structure

- Shared package `mips_defs`:
  - ALU control codes `ALU_DIV` = 6'b011100 and `ALU_DIVU` = 6'b001100, also used by the hazard unit and the ALU.
  - State enum `div_state_t` {IDLE, BUSY, DONE}.
- Sub-module `div_step`: purely combinational, one restoring iteration.
  - In: partial remainder (WIDTH+1), divisor (WIDTH+1).
  - Out: next remainder, quotient bit.
- Top module: FSM, counter, operand/sign latches, final negation.

## Test plan

- DIVU 100 / 7 with `start` at T → `ready` only at T+33; `result` = {0x00000002, 0x0000000E}; `busy` high T+1..T+33.
- DIV -7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- DIVU 5 / 0 → `ready` at T+1; `result` = {0x00000005, 0xFFFFFFFF}.
- `annul` at T+10 → IDLE at T+11, no `ready`, `result` unchanged. A new start at T+12 of 9/3 → {0, 3} at T+45.
- `start` held high through BUSY → no restart. A second divide with `start` in the cycle after DONE → accepted, `ready` exactly 34 cycles after the first `ready`.
- `resetn` low at T+5 → all outputs 0 immediately (asynchronously). After release, the next DIVU 8/2 → {0, 4} 33 cycles after `start`.

Source files
------------

// File: rtl/div_seq_pkg.sv
// -----------------------------------------------------------------------------
// mips_defs
//   Definitions shared by the execute-stage divider, the hazard unit and the
//   ALU decoder.
//   - ALU_DIV / ALU_DIVU : alucontrolE codes for signed / unsigned divide
//   - div_state_t        : divider sequencer states
//   - is_div()           : true when an alucontrol code is a divide
// -----------------------------------------------------------------------------
package mips_defs;

   localparam logic [5:0] ALU_DIV  = 6'b011100;
   localparam logic [5:0] ALU_DIVU = 6'b001100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Start qualifier for the divider, as decoded from alucontrolE.
   function automatic logic is_div(input logic [5:0] alucontrol);
      return (alucontrol == ALU_DIV) || (alucontrol == ALU_DIVU);
   endfunction

endpackage

// File: rtl/div_seq_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One radix-2 restoring division iteration, purely combinational.
//   Ports:
//     part_rem (in,  WIDTH+1) : partial remainder with the next dividend bit
//                               already shifted into the LSB
//     dsr      (in,  WIDTH+1) : divisor magnitude, zero-extended
//     next_rem (out, WIDTH+1) : partial remainder after the trial subtract
//     q_bit    (out, 1)       : quotient bit (inverted borrow)
// -----------------------------------------------------------------------------
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0] part_rem,
   input  logic [WIDTH:0] dsr,
   output logic [WIDTH:0] next_rem,
   output logic           q_bit
);

   // One extra bit so the MSB of the difference is the borrow.
   logic [WIDTH+1:0] diff;

   always_comb begin
      diff     = {1'b0, part_rem} - {1'b0, dsr};
      q_bit    = ~diff[WIDTH+1];
      // Keep the difference only when it did not go negative.
      next_rem = q_bit ? diff[WIDTH:0] : part_rem;
   end

endmodule

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
//   Iterative DIV/DIVU sequencer for the MIPS execute stage. One restoring step
//   per cycle; WIDTH iterations per divide. ready is the hazard unit's
//   div_ready input and pulses for one cycle with result valid.
//   Ports:
//     clk        (in)          : rising-edge clock
//     resetn     (in)          : asynchronous active-low reset
//     start      (in)          : a divide is in E
//     signed_div (in)          : 1 = DIV, 0 = DIVU (sampled with start)
//     annul      (in)          : cancel the operation in flight
//     dividend   (in,  WIDTH)  : rs operand
//     divisor    (in,  WIDTH)  : rt operand
//     result     (out, 2*WIDTH): {remainder (HI), quotient (LO)}
//     ready      (out)         : one-cycle completion pulse
//     busy       (out)         : high in BUSY and DONE
// -----------------------------------------------------------------------------
module div_seq
   import mips_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic                 signed_div,
   input  logic                 annul,
   input  logic [WIDTH-1:0]     dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic [2*WIDTH-1:0]   result,
   output logic                 ready,
   output logic                 busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   // Two's-complement negate when n is set. Magnitudes only ever come from a
   // WIDTH-bit signed value, so |most-negative| wraps to itself, which is the
   // correct unsigned magnitude (e.g. |0x80000000| = 0x80000000).
   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                               input logic             n);
      return n ? (~v + WIDTH'(1)) : v;
   endfunction

   div_state_t           state_q,  state_d;
   logic [CNT_W-1:0]     count_q,  count_d;
   logic [WIDTH:0]       rem_q,    rem_d;
   logic [WIDTH-1:0]     dvd_q,    dvd_d;     // dividend in, quotient out
   logic [WIDTH-1:0]     dsr_q,    dsr_d;
   logic                 q_neg_q,  q_neg_d;
   logic                 r_neg_q,  r_neg_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 ready_q,  ready_d;
   logic                 busy_q,   busy_d;

   logic [WIDTH:0]       step_in;
   logic [WIDTH:0]       step_rem;
   logic                 step_q;
   logic                 sgn_a;
   logic                 sgn_b;

   // A restoring remainder is always below the divisor, so its top bit never
   // carries information into the next shift.
   wire unused_rem_msb = rem_q[WIDTH];

   assign step_in = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};

   div_step #(.WIDTH(WIDTH)) u_step (
      .part_rem (step_in),
      .dsr      ({1'b0, dsr_q}),
      .next_rem (step_rem),
      .q_bit    (step_q)
   );

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      dsr_d    = dsr_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      result_d = result_q;
      sgn_a    = signed_div & dividend[WIDTH-1];
      sgn_b    = signed_div & divisor[WIDTH-1];

      case (state_q)
         IDLE: begin
            if (start && !annul) begin
               q_neg_d = sgn_a ^ sgn_b;
               r_neg_d = sgn_a;
               dvd_d   = neg_if(dividend, sgn_a);
               dsr_d   = neg_if(divisor, sgn_b);
               rem_d   = '0;
               count_d = '0;
               if (divisor == '0) begin
                  // Divide by zero: raw dividend in HI, all ones in LO.
                  state_d  = DONE;
                  result_d = {dividend, {WIDTH{1'b1}}};
               end else begin
                  state_d  = BUSY;
               end
            end
         end
         BUSY: begin
            rem_d   = step_rem;
            dvd_d   = {dvd_q[WIDTH-2:0], step_q};
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_LAST) begin
               state_d  = DONE;
               result_d = {neg_if(step_rem[WIDTH-1:0], r_neg_q),
                           neg_if({dvd_q[WIDTH-2:0], step_q}, q_neg_q)};
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Annul wins over every transition and leaves the last result intact.
      if (annul) begin
         state_d  = IDLE;
         result_d = result_q;
      end

      ready_d = (state_d == DONE);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         count_q  <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dsr_q    <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         dsr_q    <= dsr_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         result_q <= result_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   assign result = result_q;
   assign ready  = ready_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq
//   Directed bench for div_seq. Each issued divide pushes its expected result
//   and ready cycle onto a scoreboard; a monitor pops on every ready pulse.
// -----------------------------------------------------------------------------
module tb_div_seq;
   import mips_defs::*;

   logic        clk        = 1'b0;
   logic        resetn     = 1'b0;
   logic        start      = 1'b0;
   logic        signed_div = 1'b0;
   logic        annul      = 1'b0;
   logic [31:0] dividend   = '0;
   logic [31:0] divisor    = '0;
   logic [63:0] result;
   logic        ready;
   logic        busy;

   div_seq #(.WIDTH(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .signed_div (signed_div),
      .annul      (annul),
      .dividend   (dividend),
      .divisor    (divisor),
      .result     (result),
      .ready      (ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] res;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
      end
   endtask

   // Reference divider: C-style truncating signed division.
   function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sbv;
      logic signed [31:0] q;
      logic signed [31:0] r;
      if (b == 32'd0) return {a, 32'hFFFFFFFF};
      if (!s) return {a % b, a / b};
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      sa  = a;
      sbv = b;
      q   = sa / sbv;
      r   = sa % sbv;
      return {r, q};
   endfunction

   // Monitor: every ready pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (resetn && ready === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_ready", {63'b0, ready}, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("result", result, mon_e.res);
            check("ready_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   // Called at a negedge; start is presented for exactly one cycle.
   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv, input int lat, input bit push);
      start      = is_div(s ? ALU_DIV : ALU_DIVU);
      signed_div = s;
      dividend   = a;
      divisor    = b;
      if (push) sb.push_back('{expv, cyc + lat});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 80) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(sb.size()), 64'd0);
      sb.delete();
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          c;
      int          n;
      logic [31:0] a;
      logic [31:0] b;
      logic        s;

      // Reset state
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", {63'b0, ready}, 64'd0);
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_result", result, 64'd0);
      resetn = 1'b1;
      @(negedge clk);

      // DIVU 100/7 with latency and busy window
      c = cyc;
      issue(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b1);
      check("busy_first", {63'b0, busy}, 64'd1);
      while (cyc < c + 33) @(negedge clk);
      check("busy_last", {63'b0, busy}, 64'd1);
      check("ready_at_33", {63'b0, ready}, 64'd1);
      @(negedge clk);
      check("busy_after", {63'b0, busy}, 64'd0);
      drain("drain_divu100");

      // Signed and boundary cases
      issue(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b1);
      drain("drain_m7_2");
      issue(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, 1'b1);
      drain("drain_min_m1");
      issue(1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 33, 1'b1);
      drain("drain_max_1");
      issue(1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33, 1'b1);
      drain("drain_7_m2");
      issue(1'b1, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1, 1'b1);
      drain("drain_div_m5_0");

      // Random operands against the reference model
      for (int i = 0; i < 6; i++) begin
         s = i[0];
         a = $urandom;
         b = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (b == 32'd0) b = 32'd3;
         issue(s, a, b, model(s, a, b), 33, 1'b1);
         drain("drain_random");
      end

      // Divide by zero, unsigned
      issue(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1, 1'b1);
      drain("drain_divu_5_0");

      // Annul mid-operation, then restart
      c = cyc;
      issue(1'b0, 32'd1000, 32'd10, 64'd0, 33, 1'b0);
      while (cyc < c + 10) @(negedge clk);
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0;
      check("annul_busy", {63'b0, busy}, 64'd0);
      check("annul_result_kept", result, {32'd5, 32'hFFFFFFFF});
      @(negedge clk);
      issue(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b1);
      drain("drain_after_annul");

      // start held through BUSY, then back-to-back second divide
      start      = 1'b1;
      signed_div = 1'b0;
      dividend   = 32'd100;
      divisor    = 32'd7;
      sb.push_back('{{32'd2, 32'd14}, cyc + 33});
      @(negedge clk);
      dividend = 32'd1000;
      divisor  = 32'd3;
      n = 0;
      while (ready !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first_ready", {63'b0, ready}, 64'd1);
      dividend = 32'd21;
      divisor  = 32'd4;
      sb.push_back('{{32'd1, 32'd5}, cyc + 34});
      repeat (2) @(negedge clk);
      start = 1'b0;
      drain("drain_b2b");

      // Asynchronous reset mid-operation
      c = cyc;
      issue(1'b0, 32'd50, 32'd5, 64'd0, 33, 1'b0);
      while (cyc < c + 5) @(negedge clk);
      check("pre_reset_busy", {63'b0, busy}, 64'd1);
      resetn = 1'b0;
      #1;
      check("async_rst_ready", {63'b0, ready}, 64'd0);
      check("async_rst_busy", {63'b0, busy}, 64'd0);
      check("async_rst_result", result, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      issue(1'b0, 32'd8, 32'd2, {32'd0, 32'd4}, 33, 1'b1);
      drain("drain_after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
